// File: rtl/test_microservos.sv
// Self-running microservo tester: a triangle sweep ramps an 8-bit duty 0->255->0,
// and a period-latched PWM generator (instance P0) drives the servo pin.

module microservo_pwm #(
  parameter int unsigned CLK_FREQ_HZ   = 12000000,
  parameter int unsigned PWM_PERIOD_US = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_duty,
  output logic       o_period_end,
  output logic       o_out
);
  localparam longint unsigned PERIOD_CYC =
    (64'(CLK_FREQ_HZ) / 64'd1000) * 64'(PWM_PERIOD_US) / 64'd1000;
  localparam int CW = (PERIOD_CYC < 2) ? 1 : $clog2(PERIOD_CYC);
  localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD_CYC - 64'd1);
  localparam logic [CW+7:0] PERIOD_W = (CW+8)'(PERIOD_CYC);

  if (PERIOD_CYC < 2) begin : g_bad_period
    $error("microservo_pwm: PWM period must span at least 2 clock cycles");
  end

  logic [CW-1:0] r_cnt;
  logic [7:0]    r_duty_q;
  logic          r_out;
  logic          w_period_start;
  logic [7:0]    w_duty_eff;
  logic [CW+7:0] w_prod;
  logic [CW-1:0] w_high_cyc;

  assign w_period_start = (r_cnt == '0);
  assign o_period_end   = (r_cnt == LAST_CNT);

  // The compare at cnt==0 must already see the duty being latched on that same
  // clock, otherwise the first cycle of each period would use the stale value.
  assign w_duty_eff = w_period_start ? i_duty : r_duty_q;
  assign w_prod     = (CW+8)'(w_duty_eff) * PERIOD_W;
  assign w_high_cyc = CW'(w_prod >> 8);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_duty_q <= '0;
      r_out    <= 1'b0;
    end else begin
      r_cnt <= o_period_end ? '0 : r_cnt + CW'(1);
      if (w_period_start) r_duty_q <= i_duty;
      r_out <= (r_cnt < w_high_cyc);
    end
  end

  assign o_out = r_out;
endmodule

module test_microservos #(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned DUTY_STEP   = 1
) (
  output logic out,
  input  logic clk,
  input  logic rst
);
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam logic [7:0] STEP    = 8'(DUTY_STEP);
  localparam logic [7:0] UP_TURN = 8'd255 - STEP;

  if (DUTY_STEP < 1 || DUTY_STEP > 255) begin : g_bad_step
    $error("test_microservos: DUTY_STEP must be in 1..255");
  end

  dir_t       r_dir, w_dir_nxt;
  logic [7:0] r_duty, w_duty_nxt;
  logic       w_period_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir  <= DIR_UP;
      r_duty <= '0;
    end else begin
      r_dir  <= w_dir_nxt;
      r_duty <= w_duty_nxt;
    end
  end

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    w_dir_nxt  = r_dir;
    w_duty_nxt = r_duty;
    if (w_period_end) begin
      unique case (r_dir)
        DIR_UP: begin
          if (r_duty >= UP_TURN) begin
            w_duty_nxt = 8'd255;
            w_dir_nxt  = DIR_DOWN;
          end else begin
            w_duty_nxt = r_duty + STEP;
          end
        end
        DIR_DOWN: begin
          if (r_duty <= STEP) begin
            w_duty_nxt = 8'd0;
            w_dir_nxt  = DIR_UP;
          end else begin
            w_duty_nxt = r_duty - STEP;
          end
        end
        default: ;
      endcase
    end
  end

  microservo_pwm #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) P0 (
    .clk         (clk),
    .rst         (rst),
    .i_duty      (r_duty),
    .o_period_end(w_period_end),
    .o_out       (out)
  );
endmodule

// File: tb/tb_test_microservos.sv
// Scoreboard bench for test_microservos: two instances (step 1 and step 100) at
// 10 cycles per period; a triangle-sequence model predicts every period's pulse.

module tb_test_microservos;
  localparam int PERIOD = 10;

  typedef struct {
    int duty;
    int high;
  } exp_t;

  logic clk = 1'b0;
  logic rst_w [2];
  logic out_w [2];
  logic [31:0] cnt_w [2];
  logic [7:0]  dq_w  [2];

  test_microservos #(.CLK_FREQ_HZ(100000), .DUTY_STEP(1)) dut_a (
    .out(out_w[0]), .clk(clk), .rst(rst_w[0])
  );
  test_microservos #(.CLK_FREQ_HZ(100000), .DUTY_STEP(100)) dut_b (
    .out(out_w[1]), .clk(clk), .rst(rst_w[1])
  );
  defparam dut_a.P0.PWM_PERIOD_US = 100;
  defparam dut_b.P0.PWM_PERIOD_US = 100;

  assign cnt_w[0] = 32'(dut_a.P0.r_cnt);
  assign cnt_w[1] = 32'(dut_b.P0.r_cnt);
  assign dq_w[0]  = dut_a.P0.r_duty_q;
  assign dq_w[1]  = dut_b.P0.r_duty_q;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t exp_q [2][$];
  int   cyc   [2][$];
  int   pushes [2];
  int   pops   [2];
  bit   mon_on [2];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One full sweep cycle built from the rule: climb by step until 255 is
  // reached or exceeded (clamped), then descend by step until 0 (clamped).
  task automatic build_cycle(input int g, input int s);
    cyc[g].delete();
    for (int v = 0; v < 255; v += s) cyc[g].push_back(v);
    cyc[g].push_back(255);
    for (int v = 255 - s; v > 0; v -= s) cyc[g].push_back(v);
  endtask

  task automatic push_exp(input int g, input int k);
    exp_t e;
    e.duty = cyc[g][k % cyc[g].size()];
    e.high = (e.duty * PERIOD) / 256;
    exp_q[g].push_back(e);
    pushes[g]++;
  endtask

  // Monitor: out lags cnt by one clock, so the sample taken on the falling edge
  // after the n-th counting edge belongs to period n/10, slot n%10.
  bit     prev_rst  [2] = '{1'b1, 1'b1};
  int     n_s       [2] = '{0, 0};
  int     pat       [2] = '{0, 0};
  bit     prev_hi   [2] = '{1'b0, 1'b0};
  longint last_rise [2] = '{0, 0};

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mon_on[g]) begin
        if (prev_rst[g]) begin
          check($sformatf("rst_out%0d", g), int'(out_w[g]), 0);
          check($sformatf("rst_cnt%0d", g), int'(cnt_w[g]), 0);
          n_s[g]     = 0;
          pat[g]     = 0;
          prev_hi[g] = 1'b0;
        end else begin
          pat[g] |= int'(out_w[g]) << n_s[g];
          if (n_s[g] == 0 && out_w[g] == 1'b1) begin
            if (prev_hi[g]) check($sformatf("rise_to_rise%0d", g), int'($time - last_rise[g]), 100);
            last_rise[g] = $time;
          end
          if (n_s[g] == PERIOD - 1) begin
            if (exp_q[g].size() == 0) begin
              check($sformatf("sb_underflow%0d", g), 1, 0);
            end else begin
              exp_t e;
              e = exp_q[g].pop_front();
              pops[g]++;
              check($sformatf("pulse_pattern%0d_duty%0d", g, e.duty), pat[g], (1 << e.high) - 1);
              check($sformatf("duty_latched%0d", g), int'(dq_w[g]), e.duty);
            end
            prev_hi[g] = (pat[g] != 0);
            n_s[g]     = 0;
            pat[g]     = 0;
          end else begin
            n_s[g]++;
          end
        end
      end
      prev_rst[g] = rst_w[g];
    end
  end

  initial begin
    int off, n_run2, n_b;
    build_cycle(0, 1);
    build_cycle(1, 100);
    rst_w[0] = 1'b1;
    rst_w[1] = 1'b1;
    pushes   = '{0, 0};
    pops     = '{0, 0};
    mon_on   = '{1'b1, 1'b1};
    off      = int'($urandom_range(1, 4));
    n_run2   = 515 + int'($urandom_range(0, 10));
    n_b      = int'($urandom_range(14, 20));
    fork
      begin
        repeat (2) @(posedge clk);
        #1 rst_w[0] = 1'b0;
        for (int k = 0; k <= 200; k++) begin
          push_exp(0, k);
          if (k < 200) repeat (PERIOD) @(posedge clk);
        end
        // Reset lands mid-pulse inside period 200 (duty 200 -> 7 high clocks).
        repeat (1 + off) @(posedge clk);
        #1 rst_w[0] = 1'b1;
        @(posedge clk);
        #1 rst_w[0] = 1'b0;
        pushes[0] -= exp_q[0].size();
        exp_q[0].delete();
        for (int k = 0; k < n_run2; k++) begin
          push_exp(0, k);
          repeat (PERIOD) @(posedge clk);
        end
        @(negedge clk);
        #1 mon_on[0] = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 rst_w[1] = 1'b0;
        for (int k = 0; k < n_b; k++) begin
          push_exp(1, k);
          repeat (PERIOD) @(posedge clk);
        end
        @(negedge clk);
        #1 mon_on[1] = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("leftover%0d", g), exp_q[g].size(), 0);
      check($sformatf("pop_count%0d", g), pops[g], pushes[g]);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
